pi_ctrl_sat: RTL and testbench
==============================

Name: pi_ctrl_sat

Overview:
Parametrised, pipelined incremental (velocity-form) PI controller for the demodulator loop. It is the next generation of the fixed 32-bit PI stage. Additions over that stage:
- runtime fixed-point gains
- valid-qualified sampling
- output clamping with inherent anti-windup
- synchronous state clear and a saturation flag
It sits between the demodulator output and the drive/DAC path.

Parameters:
DATA_W, 32, width of ref_i, fb_i and pi_ctrl_o (signed)
GAIN_W, 16, width of kp_i and ki_i (unsigned, fixed-point)
FRAC_W, 8, fractional bits of the gains; products are arithmetic-shifted right by FRAC_W
OUT_MAX, 2147483647, upper clamp of pi_ctrl_o; must fit signed DATA_W
OUT_MIN, -2147483648, lower clamp of pi_ctrl_o; OUT_MIN < OUT_MAX
DBAND, 0, deadband half-width; used only with PI_CTRL_DBAND_EN

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
ref_i  in  DATA_W  signed setpoint
fb_i  in  DATA_W  signed measured value from the demodulator
in_valid_i  in  1  sample strobe; ref_i/fb_i are sampled only when high
clr_i  in  1  synchronous clear of all controller state
kp_i  in  GAIN_W  proportional gain (unsigned, FRAC_W fractional bits)
ki_i  in  GAIN_W  integral gain (unsigned, FRAC_W fractional bits)
pi_ctrl_o  out  DATA_W  signed clamped control output, held between updates
out_valid_o  out  1  one-cycle pulse when pi_ctrl_o has updated
sat_o  out  1  high while the last output is clamped at OUT_MAX or OUT_MIN

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-high (rst). Block is always ready; accepts one sample per cycle back-to-back. No backpressure.
- Reset (rst=1): pi_ctrl_o=0, out_valid_o=0, sat_o=0; e_prev, accumulator u and all pipeline valids are 0.
- Stage 1, on in_valid_i:
  - e = ref_i - fb_i, DATA_W+1 bits
  - d = e - e_prev, DATA_W+2 bits
  - e_prev <= e
  - e_prev updates only on valid samples; gaps freeze it.
- Stage 2:
  - delta = (kp_i*d + ki_i*e) >>> FRAC_W
  - products DATA_W+GAIN_W+3 bits signed; shift is arithmetic (floor); gains are zero-extended
  - gains are sampled in stage 2, so a gain change affects the first sample reaching stage 2 afterwards
- Stage 3:
  - s = u + delta at full width
  - u <= clamp(s, OUT_MIN, OUT_MAX)
  - pi_ctrl_o <= u_new; out_valid_o pulses
  - sat_o <= (s >= OUT_MAX) or (s <= OUT_MIN), updated only on out_valid_o
- Latency: out_valid_o asserts exactly 3 cycles after the in_valid_i cycle. No stage may stall.
- Anti-windup: u stores the clamped value. The first reversing error moves the output off the rail immediately.
- clr_i:
  - on the next edge, e_prev, u, pi_ctrl_o, sat_o and all pipeline valids go to 0; no out_valid_o is produced for in-flight samples
  - clr_i has priority over a simultaneous in_valid_i; that sample is dropped
- Overflow: the intermediate width makes wrap-around impossible for any legal inputs and gains; clamping is the only limiting.
- Reset mid-operation: in-flight samples are discarded; the first output after reset behaves as if e_prev=0.

Optional Feature:
PI_CTRL_DBAND_EN
- Defined: in stage 1, if |ref_i - fb_i| <= DBAND then e is forced to 0; d and e_prev use the forced value.
- Undefined: no deadband logic is synthesised and DBAND is ignored.

Decomposition:
- Shared package gysc_ctrl_pkg holds:
  - width-derivation constants: ERR_W = DATA_W+1, DIFF_W = DATA_W+2, PROD_W = DATA_W+GAIN_W+3
  - the saturating-clamp function, reused by later loop blocks
- One sub-module, sat_clamp: combinational wide-to-DATA_W clamp with a saturated flag, used by stage 3.

Test Plan:
- Proportional only: FRAC_W=8, kp=256, ki=0, ref=100, fb=0 held valid for 4 samples -> pi_ctrl_o=100 three cycles after the first valid, then stays 100; sat_o=0.
- Integral ramp: kp=0, ki=256, e=100 for 5 samples -> outputs 100,200,300,400,500, each 3 cycles after its input. Insert a 2-cycle valid gap: no out_valid_o during the gap and values unchanged.
- Saturation and anti-windup: OUT_MAX=1000, ki=256, kp=0, e=300 -> 300,600,900,1000 with sat_o=1 on the last and held at 1000. Then e=-100 -> 900, sat_o=0.
- Fractional floor: kp=0, ki=128 (0.5), e=-3 -> delta=-2 (floor), pi_ctrl_o=-2; e=3 -> pi_ctrl_o=-1.
- clr_i with simultaneous in_valid_i while 2 samples are in flight -> no out_valid_o for any of them; pi_ctrl_o=0 next cycle. The next sample with kp=256, e=50 gives 50.
- Async rst asserted mid-pipeline between edges -> outputs 0 immediately. After release, behaviour matches a fresh start; repeat with PI_CTRL_DBAND_EN, DBAND=5, e=4 -> output stays 0.

Source files
------------

// File: rtl/gysc_ctrl_pkg.sv
// ============================================================================
// Module   : gysc_ctrl_pkg
// Purpose  : Shared width derivations and saturating clamp for the loop blocks.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package gysc_ctrl_pkg;

   localparam int c_CLAMP_W = 128;

   function automatic int err_w(input int data_w);
      return data_w + 1;
   endfunction

   function automatic int diff_w(input int data_w);
      return data_w + 2;
   endfunction

   function automatic int prod_w(input int data_w, input int gain_w);
      return data_w + gain_w + 3;
   endfunction

   // Callers sign-extend into the wide carrier so one function serves any width.
   function automatic logic signed [c_CLAMP_W-1:0] sat_clamp_f(
      input logic signed [c_CLAMP_W-1:0] x,
      input logic signed [c_CLAMP_W-1:0] lo,
      input logic signed [c_CLAMP_W-1:0] hi
   );
      if (x > hi) return hi;
      if (x < lo) return lo;
      return x;
   endfunction

endpackage

`default_nettype wire

// File: rtl/sat_clamp.sv
// ============================================================================
// Module   : sat_clamp
// Purpose  : Combinational wide-to-OUT_W signed clamp with a saturated flag.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sat_clamp
   import gysc_ctrl_pkg::*;
#(
   parameter int     IN_W    = 53,
   parameter int     OUT_W   = 32,
   parameter longint OUT_MAX = 64'sd2147483647,
   parameter longint OUT_MIN = -64'sd2147483648
)(
   input  logic signed [IN_W-1:0]  i_val,
   output logic signed [OUT_W-1:0] o_val,
   output logic                    o_sat
);

   logic signed [c_CLAMP_W-1:0] w_x;
   logic signed [c_CLAMP_W-1:0] w_hi;
   logic signed [c_CLAMP_W-1:0] w_lo;
   logic signed [c_CLAMP_W-1:0] w_c;

   assign w_x   = c_CLAMP_W'(i_val);
   assign w_hi  = c_CLAMP_W'(OUT_MAX);
   assign w_lo  = c_CLAMP_W'(OUT_MIN);
   assign w_c   = sat_clamp_f(w_x, w_lo, w_hi);
   assign o_val = OUT_W'(w_c);
   // Landing exactly on a rail counts as saturated.
   assign o_sat = (w_x >= w_hi) || (w_x <= w_lo);

endmodule

`default_nettype wire

// File: rtl/pi_ctrl_sat.sv
// ============================================================================
// Module   : pi_ctrl_sat
// Purpose  : 3-stage velocity-form PI controller with runtime gains, clamped
//            output and anti-windup. Optional deadband via PI_CTRL_DBAND_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pi_ctrl_sat
   import gysc_ctrl_pkg::*;
#(
   parameter int     DATA_W  = 32,
   parameter int     GAIN_W  = 16,
   parameter int     FRAC_W  = 8,
   parameter longint OUT_MAX = 64'sd2147483647,
   parameter longint OUT_MIN = -64'sd2147483648,
   parameter int     DBAND   = 0
)(
   input  logic                     clk,
   input  logic                     rst,
   input  logic signed [DATA_W-1:0] ref_i,
   input  logic signed [DATA_W-1:0] fb_i,
   input  logic                     in_valid_i,
   input  logic                     clr_i,
   input  logic        [GAIN_W-1:0] kp_i,
   input  logic        [GAIN_W-1:0] ki_i,
   output logic signed [DATA_W-1:0] pi_ctrl_o,
   output logic                     out_valid_o,
   output logic                     sat_o
);

   localparam int c_ERR_W  = err_w(DATA_W);
   localparam int c_DIFF_W = diff_w(DATA_W);
   localparam int c_PROD_W = prod_w(DATA_W, GAIN_W);
   localparam int c_SUM_W  = c_PROD_W + 1;
   localparam int c_S_W    = c_SUM_W + 1;

   logic signed [c_ERR_W-1:0]  w_e_raw;
   logic signed [c_ERR_W-1:0]  w_e;
   logic signed [c_ERR_W-1:0]  r_e_prev;
   logic signed [c_DIFF_W-1:0] w_d;
   logic signed [c_DIFF_W-1:0] r_d1;
   logic                       r_v1;

   assign w_e_raw = c_ERR_W'(ref_i) - c_ERR_W'(fb_i);

`ifdef PI_CTRL_DBAND_EN
   logic signed [c_ERR_W-1:0] w_e_abs;
   assign w_e_abs = (w_e_raw < 0) ? -w_e_raw : w_e_raw;
   assign w_e     = (w_e_abs <= c_ERR_W'(DBAND)) ? '0 : w_e_raw;
`else
   assign w_e     = w_e_raw;
`endif

   assign w_d = c_DIFF_W'(w_e) - c_DIFF_W'(r_e_prev);

   // r_e_prev doubles as the stage-1 error register feeding the integral term.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_e_prev <= '0;
         r_d1     <= '0;
         r_v1     <= 1'b0;
      end else if (clr_i) begin
         r_e_prev <= '0;
         r_d1     <= '0;
         r_v1     <= 1'b0;
      end else begin
         r_v1 <= in_valid_i;
         if (in_valid_i) begin
            r_e_prev <= w_e;
            r_d1     <= w_d;
         end
      end
   end

   logic signed [c_PROD_W-1:0] w_kp;
   logic signed [c_PROD_W-1:0] w_ki;
   logic signed [c_PROD_W-1:0] w_pp;
   logic signed [c_PROD_W-1:0] w_pi;
   logic signed [c_SUM_W-1:0]  w_sum;
   logic signed [c_SUM_W-1:0]  r_delta;
   logic                       r_v2;

   assign w_kp  = c_PROD_W'({1'b0, kp_i});
   assign w_ki  = c_PROD_W'({1'b0, ki_i});
   assign w_pp  = w_kp * c_PROD_W'(r_d1);
   assign w_pi  = w_ki * c_PROD_W'(r_e_prev);
   assign w_sum = c_SUM_W'(w_pp) + c_SUM_W'(w_pi);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_delta <= '0;
         r_v2    <= 1'b0;
      end else if (clr_i) begin
         r_delta <= '0;
         r_v2    <= 1'b0;
      end else begin
         r_v2 <= r_v1;
         if (r_v1) begin
            r_delta <= w_sum >>> FRAC_W;
         end
      end
   end

   logic signed [c_S_W-1:0]    w_s;
   logic signed [DATA_W-1:0]   w_u_new;
   logic                       w_sat;
   logic signed [DATA_W-1:0]   r_u;
   logic                       r_out_valid;
   logic                       r_sat;

   assign w_s = c_S_W'(r_u) + c_S_W'(r_delta);

   sat_clamp #(
      .IN_W    (c_S_W),
      .OUT_W   (DATA_W),
      .OUT_MAX (OUT_MAX),
      .OUT_MIN (OUT_MIN)
   ) u_clamp (
      .i_val (w_s),
      .o_val (w_u_new),
      .o_sat (w_sat)
   );

   // The accumulator keeps the clamped value, so a reversal leaves the rail at once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_u         <= '0;
         r_out_valid <= 1'b0;
         r_sat       <= 1'b0;
      end else if (clr_i) begin
         r_u         <= '0;
         r_out_valid <= 1'b0;
         r_sat       <= 1'b0;
      end else begin
         r_out_valid <= r_v2;
         if (r_v2) begin
            r_u   <= w_u_new;
            r_sat <= w_sat;
         end
      end
   end

   assign pi_ctrl_o   = r_u;
   assign out_valid_o = r_out_valid;
   assign sat_o       = r_sat;

endmodule

`default_nettype wire

// File: tb/tb_pi_ctrl_sat.sv
// ============================================================================
// Module   : tb_pi_ctrl_sat
// Purpose  : Self-checking bench for pi_ctrl_sat (full-range and narrow-clamp
//            instances driven in parallel).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pi_ctrl_sat;

   localparam longint c_MAX_D = 64'sd2147483647;
   localparam longint c_MIN_D = -64'sd2147483648;
   localparam longint c_MAX_S = 64'sd1000;
   localparam longint c_MIN_S = -64'sd1000;
   localparam int     c_DB    = 5;
`ifdef PI_CTRL_DBAND_EN
   localparam bit     c_DB_ON = 1'b1;
`else
   localparam bit     c_DB_ON = 1'b0;
`endif

   logic               clk;
   logic               rst;
   logic signed [31:0] ref_i;
   logic signed [31:0] fb_i;
   logic               in_valid_i;
   logic               clr_i;
   logic [15:0]        kp_i;
   logic [15:0]        ki_i;
   logic signed [31:0] pi_ctrl_o;
   logic               out_valid_o;
   logic               sat_o;
   logic signed [31:0] y_s;
   logic               v_s;
   logic               s_s;

   int total = 0;
   int bad   = 0;

   pi_ctrl_sat #(.DBAND(c_DB)) dut (
      .clk(clk), .rst(rst), .ref_i(ref_i), .fb_i(fb_i), .in_valid_i(in_valid_i),
      .clr_i(clr_i), .kp_i(kp_i), .ki_i(ki_i), .pi_ctrl_o(pi_ctrl_o),
      .out_valid_o(out_valid_o), .sat_o(sat_o)
   );

   pi_ctrl_sat #(.OUT_MAX(c_MAX_S), .OUT_MIN(c_MIN_S), .DBAND(c_DB)) dut_s (
      .clk(clk), .rst(rst), .ref_i(ref_i), .fb_i(fb_i), .in_valid_i(in_valid_i),
      .clr_i(clr_i), .kp_i(kp_i), .ki_i(ki_i), .pi_ctrl_o(y_s),
      .out_valid_o(v_s), .sat_o(s_s)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive one cycle of inputs, let the edge take them, sample 1 time unit later.
   task automatic cyc(input longint r, input longint f, input logic v, input logic c);
      ref_i      = 32'(r);
      fb_i       = 32'(f);
      in_valid_i = v;
      clr_i      = c;
      @(posedge clk);
      #1;
      in_valid_i = 1'b0;
      clr_i      = 1'b0;
   endtask

   task automatic test_reset();
      #3;
      total++;
      if ({pi_ctrl_o, out_valid_o, sat_o, y_s, v_s, s_s} !== '0) begin
         bad++;
         $display("FAIL reset_async: got y=%0d v=%0b s=%0b ys=%0d vs=%0b ss=%0b want all 0",
                  pi_ctrl_o, out_valid_o, sat_o, y_s, v_s, s_s);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      cyc(0, 0, 0, 0);
      total++;
      if ({pi_ctrl_o, out_valid_o, sat_o} !== '0) begin
         bad++;
         $display("FAIL reset_release: got y=%0d v=%0b s=%0b want 0 0 0", pi_ctrl_o, out_valid_o, sat_o);
      end
   endtask

   task automatic test_prop();
      logic ev;
      kp_i = 16'd256; ki_i = 16'd0;
      cyc(0, 0, 0, 1);
      for (int i = 0; i < 7; i++) begin
         cyc(100, 0, logic'(i < 4), 0);
         ev = (i >= 2) && (i <= 5);
         total++;
         if (out_valid_o !== ev || pi_ctrl_o !== ((i >= 2) ? 32'sd100 : 32'sd0) || sat_o !== 1'b0) begin
            bad++;
            $display("FAIL prop[%0d]: got v=%0b y=%0d s=%0b want v=%0b y=%0d s=0",
                     i, out_valid_o, pi_ctrl_o, sat_o, ev, (i >= 2) ? 100 : 0);
         end
      end
   endtask

   task automatic test_integral();
      bit  vp [10] = '{1, 1, 1, 0, 0, 1, 1, 0, 0, 0};
      int  n = 0;
      logic ev;
      kp_i = 16'd0; ki_i = 16'd256;
      cyc(0, 0, 0, 1);
      for (int i = 0; i < 10; i++) begin
         cyc(100, 0, vp[i], 0);
         ev = 1'b0;
         if (i >= 2) ev = vp[i-2];
         if (ev) n++;
         total++;
         if (out_valid_o !== ev || pi_ctrl_o !== 32'(100 * n)) begin
            bad++;
            $display("FAIL integral[%0d]: got v=%0b y=%0d want v=%0b y=%0d",
                     i, out_valid_o, pi_ctrl_o, ev, 100 * n);
         end
      end
   endtask

   task automatic test_sat();
      int exp_y [9] = '{0, 0, 300, 600, 900, 1000, 1000, 900, 900};
      bit exp_v [9] = '{0, 0, 1, 1, 1, 1, 1, 1, 0};
      bit exp_s [9] = '{0, 0, 0, 0, 0, 1, 1, 0, 0};
      kp_i = 16'd0; ki_i = 16'd256;
      cyc(0, 0, 0, 1);
      for (int i = 0; i < 9; i++) begin
         cyc((i < 5) ? 300 : -100, 0, logic'(i < 6), 0);
         total++;
         if (v_s !== exp_v[i] || y_s !== 32'(exp_y[i]) || s_s !== exp_s[i]) begin
            bad++;
            $display("FAIL sat[%0d]: got v=%0b y=%0d s=%0b want v=%0b y=%0d s=%0b",
                     i, v_s, y_s, s_s, exp_v[i], exp_y[i], exp_s[i]);
         end
      end
   endtask

   task automatic test_floor();
      int exp_y [4] = '{0, 0, -2, -1};
      bit exp_v [4] = '{0, 0, 1, 1};
      kp_i = 16'd0; ki_i = 16'd128;
      cyc(0, 0, 0, 1);
      for (int i = 0; i < 4; i++) begin
         if (i == 0)      cyc(0, 3, 1, 0);
         else if (i == 1) cyc(3, 0, 1, 0);
         else             cyc(0, 0, 0, 0);
         total++;
         if (out_valid_o !== exp_v[i] || pi_ctrl_o !== 32'(exp_y[i])) begin
            bad++;
            $display("FAIL floor[%0d]: got v=%0b y=%0d want v=%0b y=%0d",
                     i, out_valid_o, pi_ctrl_o, exp_v[i], exp_y[i]);
         end
      end
   endtask

   task automatic test_clr();
      kp_i = 16'd256; ki_i = 16'd0;
      cyc(0, 0, 0, 1);
      cyc(20, 0, 1, 0); cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);
      total++;
      if (pi_ctrl_o !== 32'sd20 || out_valid_o !== 1'b1) begin
         bad++;
         $display("FAIL clr_pre: got y=%0d v=%0b want 20 1", pi_ctrl_o, out_valid_o);
      end
      cyc(40, 0, 1, 0); cyc(40, 0, 1, 0); cyc(70, 0, 1, 1);
      total++;
      if (pi_ctrl_o !== 32'sd0 || out_valid_o !== 1'b0 || sat_o !== 1'b0) begin
         bad++;
         $display("FAIL clr_now: got y=%0d v=%0b s=%0b want 0 0 0", pi_ctrl_o, out_valid_o, sat_o);
      end
      for (int i = 0; i < 3; i++) begin
         cyc(0, 0, 0, 0);
         total++;
         if (pi_ctrl_o !== 32'sd0 || out_valid_o !== 1'b0) begin
            bad++;
            $display("FAIL clr_drain[%0d]: got y=%0d v=%0b want 0 0", i, pi_ctrl_o, out_valid_o);
         end
      end
      cyc(50, 0, 1, 0); cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);
      total++;
      if (pi_ctrl_o !== 32'sd50 || out_valid_o !== 1'b1) begin
         bad++;
         $display("FAIL clr_after: got y=%0d v=%0b want 50 1", pi_ctrl_o, out_valid_o);
      end
   endtask

   task automatic test_async_rst();
      longint ey;
      kp_i = 16'd256; ki_i = 16'd0;
      cyc(0, 0, 0, 1);
      cyc(30, 0, 1, 0); cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);
      total++;
      if (pi_ctrl_o !== 32'sd30) begin
         bad++;
         $display("FAIL arst_pre: got y=%0d want 30", pi_ctrl_o);
      end
      cyc(60, 0, 1, 0);
      #2 rst = 1'b1;
      #1;
      total++;
      if (pi_ctrl_o !== 32'sd0 || out_valid_o !== 1'b0 || sat_o !== 1'b0) begin
         bad++;
         $display("FAIL arst_now: got y=%0d v=%0b s=%0b want 0 0 0", pi_ctrl_o, out_valid_o, sat_o);
      end
      #1 rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cyc(0, 0, 0, 0);
         total++;
         if (out_valid_o !== 1'b0 || pi_ctrl_o !== 32'sd0) begin
            bad++;
            $display("FAIL arst_drain[%0d]: got y=%0d v=%0b want 0 0", i, pi_ctrl_o, out_valid_o);
         end
      end
      cyc(60, 0, 1, 0); cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);
      total++;
      if (pi_ctrl_o !== 32'sd60 || out_valid_o !== 1'b1) begin
         bad++;
         $display("FAIL arst_fresh: got y=%0d v=%0b want 60 1", pi_ctrl_o, out_valid_o);
      end
      cyc(0, 0, 0, 1);
      cyc(4, 0, 1, 0); cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);
      ey = c_DB_ON ? 0 : 4;
      total++;
      if (pi_ctrl_o !== 32'(ey) || out_valid_o !== 1'b1 || sat_o !== 1'b0) begin
         bad++;
         $display("FAIL dband_in: got y=%0d v=%0b s=%0b want %0d 1 0", pi_ctrl_o, out_valid_o, sat_o, ey);
      end
      cyc(6, 0, 1, 0); cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);
      total++;
      if (pi_ctrl_o !== 32'sd6 || out_valid_o !== 1'b1) begin
         bad++;
         $display("FAIL dband_out: got y=%0d v=%0b want 6 1", pi_ctrl_o, out_valid_o);
      end
   endtask

   // Reference: each accepted sample produces one clamped update 3 cycles later.
   task automatic test_random();
      int     q_due [$];
      longint q_yd [$], q_ys [$];
      bit     q_sd [$], q_ss [$];
      longint ep, ud, us, e, d, dl, s, r, f, hyd, hys;
      bit     hsd, hss, evv, v, c;
      int     ri, fi;
      for (int b = 0; b < 6; b++) begin
         if (b % 2 == 1) begin
            kp_i = 16'($urandom); ki_i = 16'($urandom);
         end else begin
            kp_i = 16'($urandom_range(0, 600)); ki_i = 16'($urandom_range(0, 600));
         end
         cyc(0, 0, 0, 1);
         ep = 0; ud = 0; us = 0; hyd = 0; hys = 0; hsd = 0; hss = 0;
         q_due.delete(); q_yd.delete(); q_ys.delete(); q_sd.delete(); q_ss.delete();
         for (int t = 0; t < 60; t++) begin
            v = ($urandom_range(0, 9) < 7);
            c = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 1) == 1) begin
               ri = $urandom; fi = $urandom;
            end else begin
               ri = $urandom_range(0, 2000) - 1000; fi = $urandom_range(0, 2000) - 1000;
            end
            r = ri; f = fi;
            cyc(r, f, v, c);
            if (c) begin
               q_due.delete(); q_yd.delete(); q_ys.delete(); q_sd.delete(); q_ss.delete();
               ep = 0; ud = 0; us = 0; hyd = 0; hys = 0; hsd = 0; hss = 0;
            end else if (v) begin
               e = r - f;
               if (c_DB_ON && ((e < 0) ? -e : e) <= c_DB) e = 0;
               d  = e - ep;
               ep = e;
               dl = (longint'(kp_i) * d + longint'(ki_i) * e) >>> 8;
               s  = ud + dl;
               q_sd.push_back((s >= c_MAX_D) || (s <= c_MIN_D));
               ud = (s > c_MAX_D) ? c_MAX_D : ((s < c_MIN_D) ? c_MIN_D : s);
               q_yd.push_back(ud);
               s  = us + dl;
               q_ss.push_back((s >= c_MAX_S) || (s <= c_MIN_S));
               us = (s > c_MAX_S) ? c_MAX_S : ((s < c_MIN_S) ? c_MIN_S : s);
               q_ys.push_back(us);
               q_due.push_back(t + 2);
            end
            evv = 1'b0;
            if (q_due.size() > 0 && q_due[0] == t) begin
               evv = 1'b1;
               void'(q_due.pop_front());
               hyd = q_yd.pop_front(); hys = q_ys.pop_front();
               hsd = q_sd.pop_front(); hss = q_ss.pop_front();
            end
            total++;
            if (out_valid_o !== evv || pi_ctrl_o !== 32'(hyd) || sat_o !== hsd) begin
               bad++;
               $display("FAIL rand_full b%0d t%0d: got v=%0b y=%0d s=%0b want v=%0b y=%0d s=%0b",
                        b, t, out_valid_o, pi_ctrl_o, sat_o, evv, hyd, hsd);
            end
            total++;
            if (v_s !== evv || y_s !== 32'(hys) || s_s !== hss) begin
               bad++;
               $display("FAIL rand_narrow b%0d t%0d: got v=%0b y=%0d s=%0b want v=%0b y=%0d s=%0b",
                        b, t, v_s, y_s, s_s, evv, hys, hss);
            end
         end
      end
   endtask

   initial begin
      rst = 1'b1; ref_i = '0; fb_i = '0; in_valid_i = 1'b0; clr_i = 1'b0;
      kp_i = '0; ki_i = '0;
      test_reset();
      test_prop();
      test_integral();
      test_sat();
      test_floor();
      test_clr();
      test_async_rst();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1);
   end

endmodule

`default_nettype wire
